// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, FSM state encoding and counter sizing.
// Used by both the parametrised transmitter and the matching receiver.
package uart_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    // Counter width for a modulo-n counter, never narrower than one bit.
    function automatic int unsigned cnt_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Valid/ready word handshake between a byte producer and the UART transmitter.
interface uart_tx_param_if #(
    parameter int unsigned DATA_BITS = 8
);

    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: tick marks the last CLK cycle of each CLKS_PER_BIT period.
// clear restarts the period so a frame's first bit is always full width.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == LAST);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q <= '0;
        end else if (clear || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits, optional parity,
// 1 or 2 stop bits, each held CLKS_PER_BIT cycles; all outputs registered.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned PARITY       = PARITY_NONE,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned MSB_FIRST    = 0
) (
    input  logic           CLK,
    input  logic           RESET,
    uart_tx_param_if.slave bus,
    output logic           tx,
    output logic           busy
);

    localparam int unsigned BW = cnt_width(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    uart_state_e          state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [BW-1:0]        bit_q;
    logic                 tx_q;
    logic                 ready_q;
    logic                 busy_q;
    logic                 tick;
    logic                 accept;
    logic                 parity_bit;

    assign accept    = bus.valid && ready_q;
    assign bus.ready = ready_q;
    assign tx        = tx_q;
    assign busy      = busy_q;

    // The word stays unshifted, so parity always covers the latched value.
    assign parity_bit = (PARITY == PARITY_EVEN) ? ^shift_q : ~^shift_q;

    function automatic logic [BW-1:0] data_index(logic [BW-1:0] n);
        return (MSB_FIRST != 0) ? LAST_BIT - n : n;
    endfunction

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .CLK  (CLK),
        .RESET(RESET),
        .clear(accept),
        .tick (tick)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            shift_q <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        shift_q <= bus.data;
                        bit_q   <= '0;
                        tx_q    <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (tick) begin
                        tx_q    <= shift_q[data_index('0)];
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (tick) begin
                        if (bit_q == LAST_BIT) begin
                            bit_q <= '0;
                            if (PARITY != PARITY_NONE) begin
                                tx_q    <= parity_bit;
                                state_q <= StParity;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= StStop;
                            end
                        end else begin
                            bit_q <= bit_q + BW'(1);
                            tx_q  <= shift_q[data_index(bit_q + BW'(1))];
                        end
                    end
                end
                StParity: begin
                    if (tick) begin
                        tx_q    <= 1'b1;
                        state_q <= StStop;
                    end
                end
                StStop: begin
                    if (tick) begin
                        if (bit_q == LAST_STOP) begin
                            bit_q   <= '0;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            bit_q <= bit_q + BW'(1);
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: six parameter sets driven in lockstep and compared
// every cycle against a frame-list model of the serial line.
module tb_uart_tx_param;
    import uart_pkg::*;

    localparam int N = 6;
    localparam int unsigned CFG_DB  [N] = '{8, 8, 8, 8, 5, 9};
    localparam int unsigned CFG_CPB [N] = '{4, 4, 4, 4, 1, 3};
    localparam int unsigned CFG_PAR [N] = '{PARITY_NONE, PARITY_EVEN, PARITY_ODD,
                                            PARITY_NONE, PARITY_NONE, PARITY_ODD};
    localparam int unsigned CFG_STOP[N] = '{1, 1, 1, 2, 1, 2};
    localparam int unsigned CFG_MSB [N] = '{0, 0, 0, 1, 0, 1};

    logic       CLK = 1'b0;
    logic       RESET;
    logic       valid_r [N];
    logic [8:0] data_r  [N];
    logic       ready_w [N];
    logic       tx_w    [N];
    logic       busy_w  [N];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model state: expected frame per instance and position in it.
    bit active    [N];
    bit idle_seen [N];
    int pos       [N];
    int flen      [N];
    bit frame     [N][16];
    int hs_cyc    [N];
    int hs_prev   [N];
    int hs_cnt    [N];
    int lat       [N];
    bit lat_pend  [N];

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < N; g++) begin : gen_dut
        uart_tx_param_if #(.DATA_BITS(CFG_DB[g])) bus ();

        assign bus.valid  = valid_r[g];
        assign bus.data   = data_r[g][CFG_DB[g]-1:0];
        assign ready_w[g] = bus.ready;

        uart_tx_param #(
            .DATA_BITS   (CFG_DB[g]),
            .CLKS_PER_BIT(CFG_CPB[g]),
            .PARITY      (CFG_PAR[g]),
            .STOP_BITS   (CFG_STOP[g]),
            .MSB_FIRST   (CFG_MSB[g])
        ) dut (
            .CLK  (CLK),
            .RESET(RESET),
            .bus  (bus),
            .tx   (tx_w[g]),
            .busy (busy_w[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Serial line bits of one frame, first bit on the wire at index 0.
    function automatic int build(input int i, input logic [8:0] d, output bit f[16]);
        int n = 0;
        int ones = 0;
        int db = int'(CFG_DB[i]);
        for (int k = 0; k < 16; k++) f[k] = 1'b0;
        f[n] = 1'b0;
        n++;
        for (int k = 0; k < db; k++) begin
            int b = (CFG_MSB[i] != 0) ? db - 1 - k : k;
            f[n] = d[b];
            ones += int'(d[b]);
            n++;
        end
        if (CFG_PAR[i] == PARITY_EVEN) begin
            f[n] = (ones % 2) == 1;
            n++;
        end else if (CFG_PAR[i] == PARITY_ODD) begin
            f[n] = (ones % 2) == 0;
            n++;
        end
        for (int s = 0; s < int'(CFG_STOP[i]); s++) begin
            f[n] = 1'b1;
            n++;
        end
        return n;
    endfunction

    function automatic logic [15:0] frame_vec(input int i, input logic [8:0] d);
        bit f[16];
        int n;
        logic [15:0] v = '0;
        n = build(i, d, f);
        for (int k = 0; k < n; k++) v = {v[14:0], f[k]};
        return v;
    endfunction

    function automatic int frame_cycles(input int i);
        int bits = 1 + int'(CFG_DB[i]) + ((CFG_PAR[i] != PARITY_NONE) ? 1 : 0)
                   + int'(CFG_STOP[i]);
        return bits * int'(CFG_CPB[i]) + 1;
    endfunction

    // One clock: model accepts at the rising edge, outputs compared at the falling edge.
    task automatic cycle();
        bit f[16];
        @(posedge CLK);
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (RESET) begin
                active[i]    = 1'b0;
                idle_seen[i] = 1'b1;
                lat_pend[i]  = 1'b0;
            end else if (idle_seen[i] && valid_r[i]) begin
                flen[i] = build(i, data_r[i], f);
                for (int k = 0; k < 16; k++) frame[i][k] = f[k];
                pos[i]       = 0;
                active[i]    = 1'b1;
                idle_seen[i] = 1'b0;
                hs_prev[i]   = hs_cyc[i];
                hs_cyc[i]    = cyc;
                hs_cnt[i]++;
                lat_pend[i]  = 1'b1;
            end
        end
        @(negedge CLK);
        for (int i = 0; i < N; i++) begin
            if (lat_pend[i] && cyc > hs_cyc[i] && ready_w[i] === 1'b1) begin
                lat[i]      = cyc - hs_cyc[i] + 1;
                lat_pend[i] = 1'b0;
            end
            if (active[i]) begin
                check($sformatf("tx[%0d]", i), 32'(tx_w[i]),
                      32'(frame[i][pos[i] / int'(CFG_CPB[i])]));
                check($sformatf("ready[%0d]", i), 32'(ready_w[i]), 32'd0);
                check($sformatf("busy[%0d]", i), 32'(busy_w[i]), 32'd1);
                pos[i]++;
                if (pos[i] == flen[i] * int'(CFG_CPB[i])) active[i] = 1'b0;
            end else begin
                check($sformatf("idle_tx[%0d]", i), 32'(tx_w[i]), 32'd1);
                check($sformatf("idle_ready[%0d]", i), 32'(ready_w[i]), 32'd1);
                check($sformatf("idle_busy[%0d]", i), 32'(busy_w[i]), 32'd0);
                idle_seen[i] = 1'b1;
            end
        end
    endtask

    task automatic wait_hs(input int i, input int limit);
        int start = hs_cnt[i];
        for (int k = 0; k < limit && hs_cnt[i] == start; k++) cycle();
        check($sformatf("handshake_seen[%0d]", i), 32'(hs_cnt[i] - start), 32'd1);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        RESET = 1'b1;
        for (int i = 0; i < N; i++) begin
            valid_r[i]   = 1'b0;
            data_r[i]    = '0;
            active[i]    = 1'b0;
            idle_seen[i] = 1'b1;
            hs_cnt[i]    = 0;
            hs_cyc[i]    = 0;
            hs_prev[i]   = 0;
            lat[i]       = -1;
            lat_pend[i]  = 1'b0;
        end
        run(2);
        RESET = 1'b0;

        // Hand-computed frames pin the model.
        check("model_8n1_a5",   32'(frame_vec(0, 9'h0A5)), 32'(16'b01_0100_1011));
        check("model_even_a5",  32'(frame_vec(1, 9'h0A5)), 32'(16'b010_1001_0101));
        check("model_even_01",  32'(frame_vec(1, 9'h001)), 32'(16'b010_0000_0011));
        check("model_odd_01",   32'(frame_vec(2, 9'h001)), 32'(16'b010_0000_0001));
        check("model_msb2s_a5", 32'(frame_vec(3, 9'h0A5)), 32'(16'b010_1001_0111));
        check("model_5n1_1f",   32'(frame_vec(4, 9'h01F)), 32'(16'b011_1111));

        // One frame on every instance at once.
        data_r[0] = 9'h0A5;
        data_r[1] = 9'h0A5;
        data_r[2] = 9'h001;
        data_r[3] = 9'h0A5;
        data_r[4] = 9'h01F;
        data_r[5] = 9'h1A5;
        for (int i = 0; i < N; i++) valid_r[i] = 1'b1;
        wait_hs(0, 4);
        for (int i = 0; i < N; i++) valid_r[i] = 1'b0;
        run(60);
        check("latency_8n1", 32'(lat[0]), 32'd41);
        check("latency_msb2s", 32'(lat[3]), 32'd45);
        check("latency_5n1_cpb1", 32'(lat[4]), 32'd8);
        for (int i = 0; i < N; i++) begin
            check($sformatf("latency[%0d]", i), 32'(lat[i]), 32'(frame_cycles(i)));
        end

        data_r[1] = 9'h001;
        valid_r[1] = 1'b1;
        wait_hs(1, 4);
        valid_r[1] = 1'b0;
        run(50);

        // Valid held across two frames; data churns mid-frame.
        data_r[0] = 9'h055;
        valid_r[0] = 1'b1;
        wait_hs(0, 4);
        data_r[0] = 9'h0AA;
        wait_hs(0, 60);
        check("back_to_back_gap", 32'(hs_cyc[0] - hs_prev[0]), 32'd41);
        valid_r[0] = 1'b0;
        for (int k = 0; k < 45; k++) begin
            data_r[0] = 9'($urandom);
            cycle();
        end

        // Reset while the fourth data bit is on the line.
        data_r[0] = 9'h0A5;
        valid_r[0] = 1'b1;
        wait_hs(0, 4);
        valid_r[0] = 1'b0;
        run(17);
        check("pre_reset_tx", 32'(tx_w[0]), 32'd0);
        RESET = 1'b1;
        #1;
        check("reset_tx_async", 32'(tx_w[0]), 32'd1);
        check("reset_ready_async", 32'(ready_w[0]), 32'd1);
        check("reset_busy_async", 32'(busy_w[0]), 32'd0);
        run(2);
        RESET = 1'b0;
        data_r[0] = 9'h0C3;
        valid_r[0] = 1'b1;
        wait_hs(0, 4);
        valid_r[0] = 1'b0;
        run(45);
        check("post_reset_latency", 32'(lat[0]), 32'd41);

        // Random traffic on all instances.
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++) begin
                valid_r[i] = ($urandom_range(0, 3) == 0);
                data_r[i]  = 9'($urandom);
            end
            cycle();
        end
        for (int i = 0; i < N; i++) valid_r[i] = 1'b0;
        run(60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
